// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: PC sequencer, one-outstanding imem handshake and a DEPTH-entry {pc, instr} FIFO.
// Define FETCH_STATS_EN to build the fetch_cnt / flush_cnt statistics counters.
module rv_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              flush_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                     state;
  logic [XLEN-1:0]            fetch_pc, pend_pc;
  logic                       drop;
  logic [AW-1:0]              rd_ptr, wr_ptr;
  logic [DEPTH-1:0][XLEN-1:0] q_pc, q_instr;
  logic                       push, pop;
  logic [CW-1:0]              count_nxt;
  logic                       rpc_unused;

  assign rpc_unused = ^redirect_pc[1:0];

  // Redirect masks both queue ports so the flush cannot race a push or pop.
  assign push      = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign imem_req  = (state == S_REQ);
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? q_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? q_instr[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            // The fetch just granted is stale; swallow its response.
            state <= S_WAIT;
            drop  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case (state)
        S_IDLE: if (count < CW'(DEPTH)) state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop  <= 1'b0;
            state <= (count_nxt < CW'(DEPTH)) ? S_REQ : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= pend_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)     fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
